// File: rtl/hh_spike_detector_pkg.sv
// Shared types for the spike detector: voltage and timestamp words plus the detector state enum.
package hh_spike_detector_pkg;

    localparam int VOLT_W    = 22;
    localparam int TS_W      = 16;
    localparam int REFRACT_W = 8;

    typedef logic signed [VOLT_W-1:0] volt_t;
    typedef logic [TS_W-1:0]          ts_t;

    typedef enum logic [1:0] {
        ST_BELOW   = 2'd0,
        ST_REFRACT = 2'd1,
        ST_ABOVE   = 2'd2
    } state_t;

endpackage

// File: rtl/hh_evt_fifo.sv
// Count-based event FIFO; when empty, the output holds the last popped word.
module hh_evt_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              not_empty,
    output logic              full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] last_data;
    logic              do_push;
    logic              do_pop;

    assign not_empty = (count != '0);
    assign full      = (count == CNT_FULL);
    assign do_pop    = pop && not_empty;
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign do_push   = push && (!full || do_pop);
    assign pop_data  = not_empty ? mem[rd_ptr] : last_data;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_data <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr    <= rd_ptr + AW'(1);
                last_data <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hh_spike_detector.sv
// Threshold spike detector with refractory period and timestamped event FIFO.
// Define HH_SPIKE_HYST_EN to re-arm at V_TH - V_HYST instead of V_TH.
module hh_spike_detector
    import hh_spike_detector_pkg::*;
#(
    parameter volt_t V_TH        = 22'sd100,
    parameter volt_t V_HYST      = 22'sd16,
    parameter int    REFRACT_CYC = 8,
    parameter int    FIFO_DEPTH  = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  volt_t  v_in,
    input  logic   v_valid,
    output logic   spike,
    output ts_t    evt_ts,
    output logic   evt_valid,
    input  logic   evt_ready,
    output logic [15:0] spike_cnt,
    output logic   ovf,
    output state_t state
);

`ifdef HH_SPIKE_HYST_EN
    localparam volt_t FALL_TH = V_TH - V_HYST;
`else
    localparam volt_t FALL_TH = V_TH;
`endif

    localparam logic [REFRACT_W-1:0] REFRACT_LOAD = REFRACT_W'(REFRACT_CYC);

    state_t               state_q;
    state_t               state_n;
    logic [REFRACT_W-1:0] cnt_q;
    logic [REFRACT_W-1:0] cnt_n;
    ts_t                  ts_q;
    logic [15:0]          spike_cnt_q;
    logic                 spike_q;
    logic                 ovf_q;
    logic                 fire;
    logic                 fifo_full;
    logic                 pop_accept;

    assign state     = state_q;
    assign spike     = spike_q;
    assign spike_cnt = spike_cnt_q;
    assign ovf       = ovf_q;

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        fire    = 1'b0;
        if (v_valid) begin
            unique case (state_q)
                ST_BELOW: begin
                    if (v_in > V_TH) begin
                        fire = 1'b1;
                        if (REFRACT_CYC == 0) begin
                            state_n = ST_ABOVE;
                        end else begin
                            state_n = ST_REFRACT;
                            cnt_n   = REFRACT_LOAD;
                        end
                    end
                end
                ST_REFRACT: begin
                    // The sample that takes the count to zero also leaves refractory.
                    if (cnt_q <= REFRACT_W'(1)) begin
                        cnt_n   = '0;
                        state_n = ST_ABOVE;
                    end else begin
                        cnt_n = cnt_q - REFRACT_W'(1);
                    end
                end
                ST_ABOVE: begin
                    if (v_in <= FALL_TH) begin
                        state_n = ST_BELOW;
                    end
                end
                default: state_n = ST_BELOW;
            endcase
        end
    end

    // Event handshake: an event is consumed on a cycle where evt_valid and evt_ready are both high.
    assign pop_accept = evt_valid && evt_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_BELOW;
            cnt_q       <= '0;
            ts_q        <= '0;
            spike_cnt_q <= '0;
            spike_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            spike_q <= fire;
            if (v_valid) begin
                ts_q <= ts_q + 16'd1;
            end
            if (fire) begin
                spike_cnt_q <= spike_cnt_q + 16'd1;
            end
            if (fire && fifo_full && !pop_accept) begin
                ovf_q <= 1'b1;
            end
        end
    end

    hh_evt_fifo #(
        .DATA_W (TS_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fire),
        .push_data (ts_q),
        .pop       (evt_ready),
        .pop_data  (evt_ts),
        .not_empty (evt_valid),
        .full      (fifo_full)
    );

endmodule

// File: doc/hh_spike_detector.md
HH_SPIKE_DETECTOR -- requirements
Module: hh_spike_detector

Interface
REQ-001 SHALL have parameter V_TH, default 22'sd100, signed rising spike threshold in V units.
REQ-002 SHALL have parameter V_HYST, default 22'sd16, hysteresis subtracted from V_TH for re-arm.
REQ-003 SHALL have parameter REFRACT_CYC, default 8, refractory length in valid samples (0..255).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, event buffer depth (power of 2).
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on posedge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port v_in, input, 22, signed membrane voltage sample per neuron timestep.
REQ-008 SHALL have port v_valid, input, 1, v_in valid for one cycle per timestep.
REQ-009 SHALL have port spike, output, 1, one-cycle spike pulse.
REQ-010 SHALL have port evt_ts, output, 16, timestamp of the head event.
REQ-011 SHALL have port evt_valid, output, 1, FIFO non-empty.
REQ-012 SHALL have port evt_ready, input, 1, consumer pop; a pop occurs when evt_valid and evt_ready are both high.
REQ-013 SHALL have port spike_cnt, output, 16, total detected spikes, wrapping.
REQ-014 SHALL have port ovf, output, 1, sticky event-drop flag.

Function
REQ-015 SHALL act only on cycles with v_valid=1; all other cycles hold state, timestamp and counters.
REQ-016 SHALL keep ts, a 16-bit sample counter incremented per valid sample, wrapping 0xFFFF->0x0000; an event carries the ts value before the increment.
REQ-017 SHALL implement states BELOW, REFRACT, ABOVE; comparisons signed 22-bit.
REQ-018 In BELOW, v_in > V_TH SHALL fire: next cycle spike=1, spike_cnt+1, push ts; go to REFRACT (or ABOVE if REFRACT_CYC=0); v_in == V_TH does not fire.
REQ-019 In REFRACT, SHALL load the counter with REFRACT_CYC on fire, decrement per valid sample, ignore v_in, and move to ABOVE on the sample where the count reaches 0.
REQ-020 In ABOVE, v_in <= fall threshold SHALL move to BELOW without firing; a new spike requires a later sample.
REQ-021 Spike latency SHALL be exactly 1 cycle after the firing sample edge; spike never exceeds 1 cycle.
REQ-022 FIFO push SHALL occur at the firing edge; evt_valid SHALL rise the next cycle if the FIFO was empty.
REQ-023 Push when full with no simultaneous pop SHALL drop the event and set ovf; spike and spike_cnt still update.
REQ-024 Push and pop in the same cycle when full SHALL accept both; occupancy is unchanged and ovf is not set.
REQ-025 Pop when empty SHALL be ignored; evt_ts holds its last value.

Reset
REQ-026 Reset SHALL set state=BELOW, ts=0, spike_cnt=0, refractory count=0, FIFO empty, spike=0, evt_valid=0, evt_ts=0, ovf=0.
REQ-027 Reset mid-refractory or with FIFO occupied SHALL discard everything; reset overrides v_valid and evt_ready in that cycle.

Configuration
REQ-028 With HH_SPIKE_HYST_EN defined, fall threshold SHALL be V_TH - V_HYST; without it, fall threshold SHALL be V_TH.

Structure
REQ-029 A shared package SHALL hold the 22-bit voltage type, the 16-bit timestamp type and the state enum.
REQ-030 The event buffer SHALL be a sub-module hh_evt_fifo (data width 16, depth FIFO_DEPTH, count-based full/empty).

Verification
REQ-031 v_in 0,50,101,101 valid each cycle -> one spike 1 cycle after sample 3, event ts=2, spike_cnt=1.
REQ-032 v_in=100 held -> no spike; then 101 -> spike; 100 == V_TH boundary never fires.
REQ-033 REFRACT_CYC=8, v_in alternating 200/-50 -> spikes at ts 0 and 10 only (refractory, then ABOVE re-arm).
REQ-034 HYST_EN on, after spike v_in=90 then 110 -> no second spike; v_in=84 then 110 -> second spike. HYST_EN off -> 90 then 110 fires.
REQ-035 evt_ready=0, 5 spikes with depth 4 -> ovf=1, spike_cnt=5, 4 events popped in order; full plus simultaneous pop/push -> no ovf.
REQ-036 Reset asserted in REFRACT with 2 queued events -> next cycle evt_valid=0, ts=0, spike_cnt=0, v_in=101 fires with ts=0.
